// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus: imem request/response, hazard inputs and IF register drive.
// Latency: none, plain wires.
// Backpressure: imem_rdy throttles accepts; stall freezes the fetch stage.
interface fetch_ctrl_if;
    // Instruction memory side
    logic        imem_rdy;
    logic [15:0] imem_data;
    logic [7:0]  imem_addr;
    logic        imem_req;
    // Later-stage control
    logic        stall;
    logic        br_taken;
    logic [7:0]  br_target;
    // IF pipeline register drive
    logic        if_en;
    logic [7:0]  pc2;
    logic [15:0] inst;
    // Status
    logic        imem_err;
    logic        halted;

    // Fetch sequencer view
    modport master (
        input  imem_rdy, imem_data, stall, br_taken, br_target,
        output imem_addr, imem_req, if_en, pc2, inst, imem_err, halted
    );

    // Environment view (memory, hazard unit, IF register)
    modport slave (
        output imem_rdy, imem_data, stall, br_taken, br_target,
        input  imem_addr, imem_req, if_en, pc2, inst, imem_err, halted
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, requests imem, loads the IF register, bubbles on redirect.
// Latency: accepted word reaches the IF register at the edge ending the accept cycle.
// Backpressure: stall holds pc with no request; imem_rdy=0 holds pc and counts toward imem_err.
// Optional: FETCH_HALT_EN adds a HALT state entered after fetching an opcode 4'hF word.
module fetch_ctrl (
    input  logic          clk,
    input  logic          rst,
    fetch_ctrl_if.master  bus
);

`ifdef FETCH_HALT_EN
    typedef enum logic {ST_FETCH, ST_HALT} state_t;
`else
    typedef enum logic {ST_FETCH} state_t;
`endif

    localparam logic [3:0] WAIT_MAX = 4'hF;

    state_t      state, state_nx;
    logic [7:0]  pc, pc_nx;
    logic [3:0]  wait_cnt, wait_cnt_nx;
    logic        err, err_nx;

    logic        req;
    logic        load;
    logic [15:0] inst_c;
    logic [7:0]  pc2_c;
    logic        halt_st;

`ifdef FETCH_HALT_EN
    assign halt_st = (state == ST_HALT);
`else
    assign halt_st = 1'b0;
`endif

    // Register update: pc, state, wait counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_FETCH;
            pc       <= 8'h00;
            wait_cnt <= 4'h0;
            err      <= 1'b0;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            wait_cnt <= wait_cnt_nx;
            err      <= err_nx;
        end
    end

    // Next-state and IF-register drive; priority is rst, redirect, stall, accept.
    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        wait_cnt_nx = wait_cnt;
        err_nx      = err;
        req         = 1'b0;
        load        = 1'b0;
        inst_c      = 16'h0000;
        pc2_c       = 8'h00;

        if (rst) begin
            // Registers are reset by the sequential block; outputs stay quiet.
            wait_cnt_nx = 4'h0;
        end else if (bus.br_taken) begin
            // Load a NOP bubble into IF and restart at the halfword-aligned target.
            load        = 1'b1;
            pc_nx       = bus.br_target & 8'hFE;
            state_nx    = ST_FETCH;
            wait_cnt_nx = 4'h0;
        end else if (bus.stall) begin
            // Freeze: no request, pc holds so the same word is refetched on release.
            wait_cnt_nx = 4'h0;
        end else if (halt_st) begin
            // Parked until a redirect or reset.
            wait_cnt_nx = wait_cnt;
        end else begin
            req = 1'b1;
            if (bus.imem_rdy) begin
                load        = 1'b1;
                inst_c      = bus.imem_data;
                pc2_c       = pc + 8'd2;
                pc_nx       = pc + 8'd2;
                wait_cnt_nx = 4'h0;
`ifdef FETCH_HALT_EN
                if (bus.imem_data[15:12] == 4'hF) begin
                    state_nx = ST_HALT;
                end
`endif
            end else if (wait_cnt != WAIT_MAX) begin
                wait_cnt_nx = wait_cnt + 4'd1;
            end
        end

        // The flag latches on the edge where the counter hits its ceiling.
        if (wait_cnt_nx == WAIT_MAX) begin
            err_nx = 1'b1;
        end
    end

    // During reset the outputs already show their reset values.
    assign bus.imem_addr = rst ? 8'h00 : pc;
    assign bus.imem_req  = req;
    assign bus.if_en     = load;
    assign bus.inst      = inst_c;
    assign bus.pc2       = pc2_c;
    assign bus.imem_err  = rst ? 1'b0 : err;
    assign bus.halted    = rst ? 1'b0 : halt_st;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: scoreboard of expected IF-register loads plus direct status checks.
// Latency: IF loads are compared in the cycle if_en is seen.
// Backpressure: exercised through stall, imem_rdy=0 timeout and redirects.
module tb_fetch_ctrl;

    logic clk;
    logic rst;

    fetch_ctrl_if bus ();

    fetch_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [15:0] inst;
        logic [7:0]  pc2;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic [15:0] data, input logic stl,
                         input logic br, input logic [7:0] tgt);
        bus.imem_rdy  = rdy;
        bus.imem_data = data;
        bus.stall     = stl;
        bus.br_taken  = br;
        bus.br_target = tgt;
    endtask

    task automatic sb_push(input logic [15:0] inst, input logic [7:0] pc2);
        exp_t e;
        e.inst = inst;
        e.pc2  = pc2;
        sb_q.push_back(e);
    endtask

    // Sample away from the edge; any IF load is matched against the scoreboard.
    task automatic smp();
        exp_t e;
        @(negedge clk);
        if (bus.if_en) begin
            if (sb_q.size() == 0) begin
                chk("sb_extra", {31'd0, bus.if_en}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_inst", {16'd0, bus.inst}, {16'd0, e.inst});
                chk("sb_pc2", {24'd0, bus.pc2}, {24'd0, e.pc2});
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 16'hABCD, 1'b0, 1'b0, 8'h00);
        repeat (2) begin
            smp();
            chk("rst_req",   {31'd0, bus.imem_req}, 32'd0);
            chk("rst_ifen",  {31'd0, bus.if_en}, 32'd0);
            chk("rst_inst",  {16'd0, bus.inst}, 32'd0);
            chk("rst_pc2",   {24'd0, bus.pc2}, 32'd0);
            chk("rst_addr",  {24'd0, bus.imem_addr}, 32'd0);
            chk("rst_err",   {31'd0, bus.imem_err}, 32'd0);
            chk("rst_halt",  {31'd0, bus.halted}, 32'd0);
            adv();
        end
        rst = 1'b0;

        // Back-to-back accepts from 00
        drive(1'b1, 16'h1234, 1'b0, 1'b0, 8'h00); sb_push(16'h1234, 8'h02);
        smp(); chk("f0_addr", {24'd0, bus.imem_addr}, 32'h00); chk("f0_req", {31'd0, bus.imem_req}, 32'd1);
        adv();
        drive(1'b1, 16'h5678, 1'b0, 1'b0, 8'h00); sb_push(16'h5678, 8'h04);
        smp(); chk("f1_addr", {24'd0, bus.imem_addr}, 32'h02);
        adv();

        // Stall at 04 with memory ready: nothing accepted
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'hDEAD, 1'b1, 1'b0, 8'h00);
            smp();
            chk("stl_req",  {31'd0, bus.imem_req}, 32'd0);
            chk("stl_ifen", {31'd0, bus.if_en}, 32'd0);
            chk("stl_addr", {24'd0, bus.imem_addr}, 32'h04);
            adv();
        end
        drive(1'b1, 16'h9ABC, 1'b0, 1'b0, 8'h00); sb_push(16'h9ABC, 8'h06);
        smp(); chk("rel_addr", {24'd0, bus.imem_addr}, 32'h04); chk("rel_req", {31'd0, bus.imem_req}, 32'd1);
        adv();

        // Redirect during stall, odd target
        drive(1'b0, 16'h0000, 1'b1, 1'b1, 8'h31); sb_push(16'h0000, 8'h00);
        smp(); chk("br_req", {31'd0, bus.imem_req}, 32'd0); chk("br_addr", {24'd0, bus.imem_addr}, 32'h06);
        adv();
        drive(1'b1, 16'h1111, 1'b0, 1'b0, 8'h00); sb_push(16'h1111, 8'h32);
        smp(); chk("br_tgt", {24'd0, bus.imem_addr}, 32'h30);
        adv();

        // Wrap at FE
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 8'hFE); sb_push(16'h0000, 8'h00);
        smp();
        adv();
        drive(1'b1, 16'h2222, 1'b0, 1'b0, 8'h00); sb_push(16'h2222, 8'h00);
        smp(); chk("wr_addr", {24'd0, bus.imem_addr}, 32'hFE);
        adv();

        // Memory timeout at 00
        for (int i = 1; i <= 15; i++) begin
            drive(1'b0, 16'h7777, 1'b0, 1'b0, 8'h00);
            smp();
            chk("to_req",  {31'd0, bus.imem_req}, 32'd1);
            chk("to_addr", {24'd0, bus.imem_addr}, 32'h00);
            chk("to_err0", {31'd0, bus.imem_err}, 32'd0);
            adv();
        end
        drive(1'b1, 16'h3333, 1'b0, 1'b0, 8'h00); sb_push(16'h3333, 8'h02);
        smp(); chk("to_err1", {31'd0, bus.imem_err}, 32'd1);
        adv();
        drive(1'b1, 16'h4444, 1'b0, 1'b0, 8'h00); sb_push(16'h4444, 8'h04);
        smp(); chk("to_sticky", {31'd0, bus.imem_err}, 32'd1);
        adv();

        // Reset mid-wait
        repeat (3) begin
            drive(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00);
            smp(); adv();
        end
        rst = 1'b1;
        smp(); chk("mr_err", {31'd0, bus.imem_err}, 32'd0); chk("mr_req", {31'd0, bus.imem_req}, 32'd0);
        adv();
        rst = 1'b0;
        drive(1'b1, 16'h0001, 1'b0, 1'b0, 8'h00); sb_push(16'h0001, 8'h02);
        smp(); chk("ar_addr", {24'd0, bus.imem_addr}, 32'h00); chk("ar_err", {31'd0, bus.imem_err}, 32'd0);
        chk("ar_halt", {31'd0, bus.halted}, 32'd0);
        adv();

        // Walk to 06 and fetch an opcode-F word
        drive(1'b1, 16'h0002, 1'b0, 1'b0, 8'h00); sb_push(16'h0002, 8'h04);
        smp(); adv();
        drive(1'b1, 16'h0003, 1'b0, 1'b0, 8'h00); sb_push(16'h0003, 8'h06);
        smp(); adv();
        drive(1'b1, 16'hF000, 1'b0, 1'b0, 8'h00); sb_push(16'hF000, 8'h08);
        smp(); chk("hf_addr", {24'd0, bus.imem_addr}, 32'h06);
        adv();
`ifdef FETCH_HALT_EN
        repeat (2) begin
            drive(1'b1, 16'h4444, 1'b0, 1'b0, 8'h00);
            smp();
            chk("h_halt", {31'd0, bus.halted}, 32'd1);
            chk("h_req",  {31'd0, bus.imem_req}, 32'd0);
            chk("h_ifen", {31'd0, bus.if_en}, 32'd0);
            chk("h_addr", {24'd0, bus.imem_addr}, 32'h08);
            adv();
        end
        drive(1'b1, 16'h0000, 1'b0, 1'b1, 8'h10); sb_push(16'h0000, 8'h00);
        smp(); adv();
        drive(1'b1, 16'h5555, 1'b0, 1'b0, 8'h00); sb_push(16'h5555, 8'h12);
        smp();
        chk("hr_addr", {24'd0, bus.imem_addr}, 32'h10);
        chk("hr_halt", {31'd0, bus.halted}, 32'd0);
        chk("hr_req",  {31'd0, bus.imem_req}, 32'd1);
        adv();
`else
        drive(1'b1, 16'h4444, 1'b0, 1'b0, 8'h00); sb_push(16'h4444, 8'h0A);
        smp();
        chk("nf_halt", {31'd0, bus.halted}, 32'd0);
        chk("nf_req",  {31'd0, bus.imem_req}, 32'd1);
        chk("nf_addr", {24'd0, bus.imem_addr}, 32'h08);
        adv();
`endif

        drive(1'b0, 16'h0000, 1'b1, 1'b0, 8'h00);
        smp();
        chk("sb_left", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-stage sequencer that owns the program counter and drives the IF pipeline register's enable, PC2 and instruction inputs. It issues requests to instruction memory, advances the PC by 2 per accepted 16-bit instruction, freezes the fetch stage on downstream stalls, and inserts a NOP bubble on taken-branch redirects. It sits between instruction memory and the IF/ID pipeline register, and takes stall and branch inputs from later stages.

## Interface
- No parameters. Widths are fixed: 8-bit byte-addressed PC, 16-bit instructions.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- imem_rdy  in  1  memory data valid for the current imem_addr, same cycle
- imem_data  in  16  instruction word at imem_addr
- stall  in  1  downstream hazard; fetch stage must hold
- br_taken  in  1  redirect request from the execute stage
- br_target  in  8  redirect address; bit 0 ignored
- imem_addr  out  8  current PC, registered
- imem_req  out  1  fetch request
- if_en  out  1  load enable to the IF pipeline register
- pc2  out  8  PC+2 value presented to the IF pipeline register
- inst  out  16  instruction presented to the IF pipeline register
- imem_err  out  1  sticky memory-timeout flag
- halted  out  1  fetch halted (FETCH_HALT_EN only)

## Operation
- States: FETCH and HALT. HALT exists only with FETCH_HALT_EN. State is FETCH after reset.
- Priority order: rst > br_taken > stall > memory accept.
- **Redirect** (br_taken=1, any state):
  - Outputs: if_en=1, inst=16'h0000 (NOP bubble), pc2=8'h00, imem_req=0.
  - Next: pc <= {br_target[7:1],1'b0}; state <= FETCH; wait counter cleared.
- **Stall** (stall=1, no br_taken):
  - Outputs: imem_req=0, if_en=0, inst=0, pc2=0.
  - pc holds; wait counter cleared.
- **FETCH, no stall:**
  - imem_req=1.
  - If imem_rdy=1 (accept): if_en=1, inst=imem_data, pc2=pc+2, pc <= pc+2 (mod 256, so 8'hFE wraps to 8'h00), wait counter cleared.
  - If imem_rdy=0: if_en=0, inst=0, pc2=0, pc holds.
- **Wait counter:** 4 bits. Increments on each cycle with imem_req=1 and imem_rdy=0, and saturates at 15. When it reaches 15, imem_err is set and stays set until rst; fetching continues.
- **HALT:** imem_req=0, if_en=0, halted=1. Only br_taken or rst leave HALT.
- if_en, inst and pc2 are combinational from state and inputs. pc, state, counter and imem_err are registered.

## Timing
- Reset values (during rst and on the cycle after it):
  - pc=8'h00; imem_addr=8'h00; state=FETCH; counter=0; imem_err=0; halted=0.
  - While rst=1: imem_req=0, if_en=0, inst=0, pc2=0.
- Fetch latency: an instruction accepted in cycle N is captured by the IF register at the edge ending cycle N. imem_addr shows pc+2 in cycle N+1.
- Throughput: one instruction per cycle while imem_rdy=1 and stall=0.
- Redirect: the bubble is captured at the edge ending the br_taken cycle. br_target is on imem_addr in the next cycle, and its instruction can be accepted in that cycle.
- Simultaneous br_taken and stall: redirect wins.
- Simultaneous imem_rdy and stall: no accept, pc holds.
- rst mid-wait or mid-stall: all state returns to reset values on the next edge.
- Stall released: fetch resumes at the held pc in the same cycle stall falls. No instruction is lost or duplicated.

## Configuration
- Macro: FETCH_HALT_EN.
- Defined:
  - An accepted instruction with inst[15:12]==4'hF is passed to the IF register normally (if_en=1).
  - state then goes to HALT, and pc still advances by 2.
  - halted=1 from the next cycle.
- Undefined:
  - Opcode 4'hF is fetched like any other instruction.
  - No HALT state exists; halted is tied to 0.

## Test plan
- Reset, then imem_rdy=1 continuously with words 16'h1234, 16'h5678 → imem_addr 00,02,04; if_en=1 each cycle; pc2 02,04; inst matches each word.
- Stall held for 3 cycles at pc=04 → imem_req=0 and if_en=0 for 3 cycles, imem_addr stays 04. On release, 04 is fetched once.
- br_taken=1 with br_target=8'h31 during a stall → if_en=1 with inst=0000 and pc2=00. Next imem_addr=8'h30.
- pc=8'hFE accepted → pc2=8'h00, next imem_addr=8'h00.
- imem_rdy=0 for 15 req cycles → imem_err=1 and stays 1 after later accepts; cleared only by rst.
- FETCH_HALT_EN defined, fetch 16'hF000 at 06 → if_en=1 once, then halted=1 and imem_req=0. A later br_taken to 8'h10 resumes fetch at 10.
